// File: rtl/vin_pixel_unpack.sv
// FPD-Link pixel unpacker: three 7-bit lanes become 4-bit gray pixels, packed four per 16-bit word.
// Line and frame geometry are tracked from de/vs edges. Packed words leave through a 4-deep FIFO.
module vin_pixel_unpack #(
    parameter int H_ACT = 1600,
    parameter int V_ACT = 1200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [6:0]  lane_a,
    input  logic [6:0]  lane_b,
    input  logic [6:0]  lane_c,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_sof,
    output logic        out_eol,
    output logic        err_overflow,
    output logic        err_timing,
    input  logic        err_clr
);
    localparam logic [11:0] H_CNT = 12'(H_ACT);
    localparam logic [11:0] V_CNT = 12'(V_ACT);

    logic [5:0]  red_q, green_q, blue_q;
    logic        de1_q, vs1_q, s1Valid_q;
    logic [3:0]  pix2_q;
    logic        de2_q, vs2_q, s2Valid_q;
    logic [8:0]  lumaSum;
    logic        unusedHs;

    logic        deHist_q, deHist_d, vsHist_q, vsHist_d;
    logic        synced_q, synced_d, sofPend_q, sofPend_d;
    logic [11:0] pixCnt_q, pixCnt_d, lineCnt_q, lineCnt_d, pixNext;
    logic [1:0]  packIdx_q, packIdx_d;
    logic [11:0] pack_q, pack_d;
    logic        push, timingSet;
    logic [17:0] pushWord;

    logic [17:0] fifoMem_q [4];
    logic [1:0]  wrPtr_q, rdPtr_q;
    logic [2:0]  count_q;
    logic        pop, full, doPush, overflowSet;
    logic        errOvf_q, errTiming_q;

    assign unusedHs = lane_c[4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            de1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            s1Valid_q <= 1'b0;
        end else if (in_valid) begin
            red_q     <= lane_a[5:0];
            green_q   <= {lane_b[4:0], lane_a[6]};
            blue_q    <= {lane_c[3:0], lane_b[6:5]};
            de1_q     <= lane_c[6];
            vs1_q     <= lane_c[5];
            s1Valid_q <= 1'b1;
        end
    end

    // 2r + 5g + b peaks at 504, so 9 bits suffice. The pixel is bits [5:2] of y6 = sum >> 3.
    assign lumaSum = {2'b00, red_q, 1'b0} + {1'b0, green_q, 2'b00} + {3'b000, green_q} + {3'b000, blue_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix2_q    <= '0;
            de2_q     <= 1'b0;
            vs2_q     <= 1'b0;
            s2Valid_q <= 1'b0;
        end else if (in_valid) begin
            pix2_q    <= 4'(lumaSum >> 5);
            de2_q     <= de1_q;
            vs2_q     <= vs1_q;
            s2Valid_q <= s1Valid_q;
        end
    end

    // No word is written until the first vs rise after reset, so a mid-frame reset resynchronises cleanly.
    always_comb begin
        deHist_d  = deHist_q;
        vsHist_d  = vsHist_q;
        synced_d  = synced_q;
        sofPend_d = sofPend_q;
        pixCnt_d  = pixCnt_q;
        lineCnt_d = lineCnt_q;
        packIdx_d = packIdx_q;
        pack_d    = pack_q;
        pixNext   = '0;
        push      = 1'b0;
        pushWord  = '0;
        timingSet = 1'b0;
        if (in_valid && s2Valid_q) begin
            deHist_d = de2_q;
            vsHist_d = vs2_q;
            if (vs2_q && !vsHist_q) begin
                timingSet = synced_q && (lineCnt_q != V_CNT);
                synced_d  = 1'b1;
                lineCnt_d = '0;
                pixCnt_d  = '0;
                packIdx_d = '0;
                sofPend_d = 1'b1;
            end else if (de2_q) begin
                pixNext  = deHist_q ? pixCnt_q + 12'd1 : 12'd1;
                pixCnt_d = pixNext;
                if (packIdx_q == 2'd3) begin
                    push      = synced_q;
                    pushWord  = {pix2_q, pack_q, sofPend_q, pixNext == H_CNT};
                    packIdx_d = '0;
                    if (synced_q) begin
                        sofPend_d = 1'b0;
                    end
                end else begin
                    case (packIdx_q)
                        2'd0:    pack_d[3:0]  = pix2_q;
                        2'd1:    pack_d[7:4]  = pix2_q;
                        2'd2:    pack_d[11:8] = pix2_q;
                        default: ;
                    endcase
                    packIdx_d = packIdx_q + 2'd1;
                end
            end else if (deHist_q) begin
                timingSet = synced_q && ((pixCnt_q != H_CNT) || (packIdx_q != 2'd0));
                lineCnt_d = lineCnt_q + 12'd1;
                packIdx_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deHist_q  <= 1'b0;
            vsHist_q  <= 1'b0;
            synced_q  <= 1'b0;
            sofPend_q <= 1'b0;
            pixCnt_q  <= '0;
            lineCnt_q <= '0;
            packIdx_q <= '0;
            pack_q    <= '0;
        end else begin
            deHist_q  <= deHist_d;
            vsHist_q  <= vsHist_d;
            synced_q  <= synced_d;
            sofPend_q <= sofPend_d;
            pixCnt_q  <= pixCnt_d;
            lineCnt_q <= lineCnt_d;
            packIdx_q <= packIdx_d;
            pack_q    <= pack_d;
        end
    end

    assign full        = (count_q == 3'd4);
    assign pop         = (count_q != 3'd0) && out_ready;
    assign doPush      = push && (!full || pop);
    assign overflowSet = push && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                fifoMem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                fifoMem_q[wrPtr_q] <= pushWord;
                wrPtr_q            <= wrPtr_q + 2'd1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 2'd1;
            end
            case ({doPush, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // A same-cycle set wins over err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errOvf_q    <= 1'b0;
            errTiming_q <= 1'b0;
        end else begin
            errOvf_q    <= (errOvf_q & ~err_clr) | overflowSet;
            errTiming_q <= (errTiming_q & ~err_clr) | timingSet;
        end
    end

    assign out_valid                    = (count_q != 3'd0);
    assign {out_data, out_sof, out_eol} = fifoMem_q[rdPtr_q];
    assign err_overflow                 = errOvf_q;
    assign err_timing                   = errTiming_q;
endmodule

// File: tb/tb_vin_pixel_unpack.sv
// Directed bench for vin_pixel_unpack: expected words are queued as pixels are driven and
// compared when the DUT hands them over.
module tb_vin_pixel_unpack;
    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst_n, in_valid, out_ready, err_clr;
    logic [6:0]  lane_a, lane_b, lane_c;
    logic        out_valid, out_sof, out_eol, err_overflow, err_timing;
    logic [15:0] out_data;

    int          errors = 0;
    int          checks = 0;
    logic [17:0] expQ[$];
    int          pushBudget = -1;
    bit          sofPend = 1'b0;

    always #5 clk = ~clk;

    vin_pixel_unpack #(.H_ACT(H), .V_ACT(V)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
        .lane_a(lane_a), .lane_b(lane_b), .lane_c(lane_c),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol),
        .err_overflow(err_overflow), .err_timing(err_timing), .err_clr(err_clr)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [3:0] lumaModel(input int r, input int g, input int b);
        int y6;
        y6 = (2 * r + 5 * g + b) / 8;
        return 4'(y6 / 4);
    endfunction

    task automatic applyStimulus(input bit vld, input logic [5:0] r, input logic [5:0] g,
                                 input logic [5:0] b, input bit de, input bit vs);
        in_valid = vld;
        lane_a   = {g[0], r};
        lane_b   = {b[1:0], g[5:1]};
        lane_c   = {de, vs, 1'b0, b[5:2]};
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input logic [17:0] w);
        if (pushBudget != 0) begin
            expQ.push_back(w);
            if (pushBudget > 0) pushBudget--;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0);
    endtask

    // Modes: 0 r=g=b=index, 1 all 63, 2 pure red, otherwise random. An ignored cycle follows pixel 1.
    task automatic sendLine(input int nPix, input int mode);
        logic [5:0]  r, g, b;
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < nPix; i++) begin
            case (mode)
                0:       begin r = 6'(i);   g = 6'(i);   b = 6'(i);   end
                1:       begin r = 6'd63;   g = 6'd63;   b = 6'd63;   end
                2:       begin r = 6'd63;   g = 6'd0;    b = 6'd0;    end
                default: begin r = 6'($urandom); g = 6'($urandom); b = 6'($urandom); end
            endcase
            acc[(i % 4) * 4 +: 4] = lumaModel(r, g, b);
            applyStimulus(1'b1, r, g, b, 1'b1, 1'b0);
            if (i % 4 == 3) begin
                pushExpected({acc, sofPend, (i + 1 == H)});
                sofPend = 1'b0;
            end
            if (i == 1) applyStimulus(1'b0, 6'($urandom), 6'($urandom), 6'($urandom), 1'($urandom), 1'b1);
        end
        idle(3);
    endtask

    task automatic sendFrame(input int nLines, input int mode, input int shortLine, input int shortLen);
        sofPend = 1'b1;
        repeat (2) applyStimulus(1'b1, 6'd0, 6'd0, 6'd0, 1'b0, 1'b1);
        idle(2);
        for (int l = 0; l < nLines; l++) sendLine((l == shortLine) ? shortLen : H, mode);
    endtask

    task automatic waitDrain(input string tag);
        for (int k = 0; k < 100 && expQ.size() != 0; k++) @(posedge clk);
        #1;
        checkOutput(tag, expQ.size(), 0);
    endtask

    task automatic pulseClear();
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_valid"}, out_valid, 0);
        checkOutput({tag, "_data"}, out_data, 0);
        checkOutput({tag, "_sof"}, out_sof, 0);
        checkOutput({tag, "_eol"}, out_eol, 0);
        checkOutput({tag, "_ovf"}, err_overflow, 0);
        checkOutput({tag, "_timing"}, err_timing, 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checkOutput("word_expected", 32'(expQ.size() != 0), 32'd1);
            if (expQ.size() != 0)
                checkOutput("word", {14'd0, out_data, out_sof, out_eol}, {14'd0, expQ.pop_front()});
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
        lane_a = '0; lane_b = '0; lane_c = '0;
        #3 rst_n = 1'b0;
        #4;
        checkAllZero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;

        sendFrame(V, 0, -1, 0);
        sendFrame(V, 1, -1, 0);
        sendFrame(V, 2, -1, 0);
        sendFrame(V, 3, -1, 0);
        idle(4);
        waitDrain("drain_basic");
        checkOutput("basic_timing", err_timing, 0);
        checkOutput("basic_ovf", err_overflow, 0);

        out_ready = 1'b0;
        pushBudget = 4;
        sendFrame(V, 3, -1, 0);
        idle(4);
        checkOutput("ovf_valid", out_valid, 1);
        checkOutput("ovf_head", {14'd0, out_data, out_sof, out_eol}, {14'd0, expQ[0]});
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ovf_hold", {14'd0, out_data, out_sof, out_eol}, {14'd0, expQ[0]});
        checkOutput("ovf_flag", err_overflow, 1);
        checkOutput("ovf_timing", err_timing, 0);
        out_ready = 1'b1;
        pushBudget = -1;
        waitDrain("drain_ovf");
        pulseClear();
        checkOutput("ovf_cleared", err_overflow, 0);

        sendFrame(V, 0, 1, 6);
        idle(4);
        waitDrain("drain_short_line");
        checkOutput("short_line_timing", err_timing, 1);
        pulseClear();
        checkOutput("short_line_cleared", err_timing, 0);

        sendFrame(3, 3, -1, 0);
        idle(4);
        waitDrain("drain_short_frame");
        checkOutput("short_frame_before_vs", err_timing, 0);
        sendFrame(V, 3, -1, 0);
        idle(4);
        waitDrain("drain_after_short_frame");
        checkOutput("short_frame_after_vs", err_timing, 1);

        out_ready = 1'b0;
        pushBudget = 0;
        sendFrame(1, 3, -1, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 6'($urandom), 6'($urandom), 6'($urandom), 1'b1, 1'b0);
        checkOutput("pre_rst_valid", out_valid, 1);
        checkOutput("pre_rst_timing", err_timing, 1);
        #2 rst_n = 1'b0;
        #1;
        checkAllZero("midrst");
        expQ.delete();
        sofPend = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 6'($urandom), 6'($urandom), 6'($urandom), 1'b1, 1'b0);
        idle(3);
        sendLine(H, 3);
        sendLine(H, 3);
        idle(4);
        checkOutput("post_rst_quiet", out_valid, 0);
        pushBudget = -1;
        sendFrame(V, 0, -1, 0);
        idle(4);
        waitDrain("drain_resync");
        checkOutput("resync_timing", err_timing, 0);
        sendFrame(V, 1, -1, 0);
        idle(4);
        waitDrain("drain_final");
        checkOutput("final_timing", err_timing, 0);
        checkOutput("final_ovf", err_overflow, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
